// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone types and bus widths
package wb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } wb_state_t;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 32;
   localparam int WB_SEL_W  = 4;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
// Scans the request vector from ptr_i upward with wrap; first set bit wins.
module rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin : pick
      int j;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_i) + i) % N;
         if (!valid_o && req_i[j]) begin
            valid_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - N-master round-robin Wishbone arbiter
// Grant is locked for the whole cycle; a watchdog answers stalled strobes with err.
module wishbone_arbiter
   import wb_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int TAGSIZE   = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic [N_MASTERS-1:0]           m_cyc_i,
   input  logic [N_MASTERS-1:0]           m_stb_i,
   input  logic [N_MASTERS-1:0]           m_we_i,
   input  logic [WB_SEL_W*N_MASTERS-1:0]  m_sel_i,
   input  logic [WB_ADDR_W*N_MASTERS-1:0] m_adr_i,
   input  logic [WB_DATA_W*N_MASTERS-1:0] m_dat_i,
   input  logic [TAGSIZE*N_MASTERS-1:0]   m_tga_i,
   input  logic [TAGSIZE*N_MASTERS-1:0]   m_tgc_i,
   input  logic [TAGSIZE*N_MASTERS-1:0]   m_tgd_i,
   output logic [WB_DATA_W-1:0]           m_dat_o,
   output logic [TAGSIZE-1:0]             m_tgd_o,
   output logic [N_MASTERS-1:0]           m_ack_o,
   output logic [N_MASTERS-1:0]           m_err_o,
   output logic [N_MASTERS-1:0]           m_rty_o,
   output logic                           s_cyc_o,
   output logic                           s_stb_o,
   output logic                           s_we_o,
   output logic [WB_SEL_W-1:0]            s_sel_o,
   output logic [WB_ADDR_W-1:0]           s_adr_o,
   output logic [WB_DATA_W-1:0]           s_dat_o,
   output logic [TAGSIZE-1:0]             s_tga_o,
   output logic [TAGSIZE-1:0]             s_tgc_o,
   output logic [TAGSIZE-1:0]             s_tgd_o,
   input  logic [WB_DATA_W-1:0]           s_dat_i,
   input  logic [TAGSIZE-1:0]             s_tgd_i,
   input  logic                           s_ack_i,
   input  logic                           s_err_i,
   input  logic                           s_rty_i,
   output logic [N_MASTERS-1:0]           grant_o
);

   localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   wb_state_t              state_q;
   logic [N_MASTERS-1:0]   grant_q;
   logic [IDX_W-1:0]       gidx_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
   logic [N_MASTERS-1:0]   pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;
   logic                   wd_fire;
   logic                   s_resp;

   rr_picker #(
      .N     (N_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (m_cyc_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign wd_fire = (TIMEOUT > 0) && (state_q == BUSY) && (wd_cnt_q == WD_W'(TIMEOUT));
   assign s_resp  = s_ack_i | s_err_i | s_rty_i;

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_tga_o = '0;
      s_tgc_o = '0;
      s_tgd_o = '0;
      if (state_q == BUSY) begin
         s_cyc_o = m_cyc_i[gidx_q];
         s_stb_o = m_cyc_i[gidx_q] & m_stb_i[gidx_q] & ~wd_fire;
         s_we_o  = m_we_i[gidx_q];
         s_sel_o = m_sel_i[gidx_q*WB_SEL_W +: WB_SEL_W];
         s_adr_o = m_adr_i[gidx_q*WB_ADDR_W +: WB_ADDR_W];
         s_dat_o = m_dat_i[gidx_q*WB_DATA_W +: WB_DATA_W];
         s_tga_o = m_tga_i[gidx_q*TAGSIZE +: TAGSIZE];
         s_tgc_o = m_tgc_i[gidx_q*TAGSIZE +: TAGSIZE];
         s_tgd_o = m_tgd_i[gidx_q*TAGSIZE +: TAGSIZE];
      end
   end

   // Responses are only honoured while a strobe is actually presented to the slave.
   assign m_ack_o = grant_q & {N_MASTERS{s_ack_i & s_stb_o}};
   assign m_err_o = grant_q & {N_MASTERS{(s_err_i & s_stb_o) | wd_fire}};
   assign m_rty_o = grant_q & {N_MASTERS{s_rty_i & s_stb_o}};
   assign m_dat_o = s_dat_i;
   assign m_tgd_o = s_tgd_i;
   assign grant_o = grant_q;

   always_comb begin
      wd_cnt_d = '0;
      if ((TIMEOUT > 0) && (state_q == BUSY) && s_stb_o && !s_resp) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick_gnt;
                  gidx_q  <= pick_idx;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!m_cyc_i[gidx_q]) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= (gidx_q == IDX_W'(N_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - directed self-checking bench for wishbone_arbiter
module tb_wishbone_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [7:0]  m_sel;
   logic [63:0] m_adr, m_dat;
   logic [3:0]  m_tga, m_tgc, m_tgd;
   logic [31:0] m_dat_o;
   logic [1:0]  m_tgd_o;
   logic [1:0]  m_ack_o, m_err_o, m_rty_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [1:0]  s_tga_o, s_tgc_o, s_tgd_o;
   logic [31:0] s_dat;
   logic [1:0]  s_tgd;
   logic        s_ack, s_err, s_rty;
   logic [1:0]  grant_o;
   logic [1:0]  exp_g;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wishbone_arbiter #(.N_MASTERS(2), .TAGSIZE(2), .TIMEOUT(16)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
      .m_adr_i(m_adr), .m_dat_i(m_dat),
      .m_tga_i(m_tga), .m_tgc_i(m_tgc), .m_tgd_i(m_tgd),
      .m_dat_o(m_dat_o), .m_tgd_o(m_tgd_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_tga_o(s_tga_o), .s_tgc_o(s_tgc_o), .s_tgd_o(s_tgd_o),
      .s_dat_i(s_dat), .s_tgd_i(s_tgd),
      .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(grant_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rstn = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0; m_sel = 8'hFF;
      m_adr = '0; m_dat = '0;
      m_tga = 4'b1001; m_tgc = 4'b0110; m_tgd = 4'b1100;
      s_dat = '0; s_tgd = '0; s_ack = 0; s_err = 0; s_rty = 0;
      step; step;
      check("rst_grant", grant_o, 0);
      check("rst_scyc", s_cyc_o, 0);
      check("rst_ack", m_ack_o, 0);
      check("rst_err", m_err_o, 0);
      rstn = 1'b1;
      step;

      // single master write
      m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
      m_adr[31:0] = 32'h100; m_dat[31:0] = 32'hDEADBEEF; m_sel[3:0] = 4'hF;
      #1;
      check("single_latency", s_cyc_o, 0);
      step;
      check("single_grant", grant_o, 2'b01);
      check("single_scyc", s_cyc_o, 1);
      check("single_adr", s_adr_o, 32'h100);
      check("single_dat", s_dat_o, 32'hDEADBEEF);
      check("single_we", s_we_o, 1);
      check("single_tga", s_tga_o, 2'b01);
      s_ack = 1; s_dat = 32'hCAFEF00D; s_tgd = 2'b10;
      #1;
      check("single_ack", m_ack_o, 2'b01);
      check("single_rdat", m_dat_o, 32'hCAFEF00D);
      check("single_rtgd", m_tgd_o, 2'b10);
      step;
      s_ack = 0; m_cyc = 0; m_stb = 0;
      #1;
      check("single_ack_once", m_ack_o, 0);
      check("single_scyc_fall", s_cyc_o, 0);
      step;
      check("single_release", grant_o, 0);

      // contention straight after reset
      rstn = 1'b0; step; rstn = 1'b1; step;
      m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00; m_adr[63:32] = 32'h200;
      step;
      check("cont_first", grant_o, 2'b01);
      check("cont_adr0", s_adr_o, 32'h100);
      s_ack = 1; #1;
      check("cont_ack0", m_ack_o, 2'b01);
      step;
      s_ack = 0; m_cyc = 2'b10; m_stb = 2'b10; #1;
      check("cont_scyc_drop", s_cyc_o, 0);
      step;
      check("cont_idle_gap", grant_o, 0);
      check("cont_idle_scyc", s_cyc_o, 0);
      step;
      check("cont_second", grant_o, 2'b10);
      check("cont_adr1", s_adr_o, 32'h200);
      s_ack = 1; #1;
      check("cont_ack1", m_ack_o, 2'b10);
      step;
      s_ack = 0; m_cyc = 0; m_stb = 0;
      step;

      // fairness: both keep requesting, single-beat transfers
      exp_g = 2'b01;
      for (int t = 0; t < 8; t++) begin
         m_cyc = 2'b11; m_stb = 2'b11;
         step;
         check("fair_grant", grant_o, exp_g);
         s_ack = 1; #1;
         check("fair_ack", m_ack_o, exp_g);
         step;
         s_ack = 0; m_cyc = ~exp_g; m_stb = ~exp_g;
         step;
         exp_g = ~exp_g;
      end
      m_cyc = 0; m_stb = 0;
      step;

      // burst lock: master1 holds cyc with strobe gaps while master0 waits
      m_cyc = 2'b10; m_stb = 2'b00;
      step;
      check("burst_grant", grant_o, 2'b10);
      m_cyc = 2'b11; m_stb = 2'b01;
      for (int b = 0; b < 4; b++) begin
         m_stb[1] = 1'b1; s_ack = 1; #1;
         check("burst_ack", m_ack_o, 2'b10);
         step;
         m_stb[1] = 1'b0; s_ack = (b == 1); #1;
         check("burst_gap_mask", m_ack_o, 0);
         check("burst_lock", grant_o, 2'b10);
         step;
      end
      s_ack = 0; m_cyc[1] = 1'b0;
      step;
      check("burst_release", grant_o, 0);
      step;
      check("burst_next", grant_o, 2'b01);
      m_cyc = 0; m_stb = 0;
      step; step;

      // watchdog: slave never answers
      m_cyc = 2'b10; m_stb = 2'b10;
      step;
      check("wd_grant", grant_o, 2'b10);
      for (int i = 0; i < 16; i++) begin
         check("wd_quiet", m_err_o, 0);
         step;
      end
      check("wd_err", m_err_o, 2'b10);
      check("wd_stb_low", s_stb_o, 0);
      step;
      check("wd_err_once", m_err_o, 0);
      check("wd_stb_back", s_stb_o, 1);
      check("wd_grant_kept", grant_o, 2'b10);
      m_cyc = 0; m_stb = 0;
      step; step;

      // reset mid-transfer, then arbitration restarts from pointer 0
      m_cyc = 2'b01; m_stb = 2'b01;
      step;
      m_cyc = 0; m_stb = 0;
      step;
      m_cyc = 2'b01; m_stb = 2'b01;
      step;
      check("rstmid_grant", grant_o, 2'b01);
      rstn = 1'b0; s_ack = 1;
      step;
      check("rstmid_grant0", grant_o, 0);
      check("rstmid_scyc", s_cyc_o, 0);
      check("rstmid_ack", m_ack_o, 0);
      check("rstmid_err", m_err_o, 0);
      rstn = 1'b1; s_ack = 0; m_cyc = 2'b11; m_stb = 2'b11;
      step;
      check("rstmid_resume", grant_o, 2'b01);
      m_cyc = 0; m_stb = 0;
      step;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
